// File: rtl/math_pkg.sv
// Shared definitions for the math_* receive-path blocks: accumulator state
// encoding and width-generic saturation / sign-extension helpers.
package math_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_t;

  // Largest signed value representable in w bits (low w bits of the result).
  function automatic logic [63:0] sat_max(input int unsigned w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Smallest signed value representable in w bits (low w bits of the result).
  function automatic logic [63:0] sat_min(input int unsigned w);
    sat_min = ~sat_max(w);
  endfunction

  // Replicate bit w-1 of v into all higher bit positions.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = v;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= w) r[i] = v[w - 1];
    end
    return r;
  endfunction

endpackage

// File: rtl/math_sat_add.sv
// Combinational signed W-bit adder with overflow flag.
// Build option MATH_ACC_SAT_EN: clamp the sum to the signed range on overflow;
// without it the sum wraps (two's complement) and only the flag is produced.
module math_sat_add
  import math_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;

  // Overflow: operands share a sign that the raw result does not.
  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
    sum_o = raw;
`ifdef MATH_ACC_SAT_EN
    if (ovf_o) begin
      sum_o = a_i[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
    end
`endif
  end

endmodule

// File: rtl/math_acc_dump.sv
// Signed integrate-and-dump accumulator fed by the math_add_fab sum stream.
// Integrates len+1 samples (or until dump) and emits one registered block sum
// with sample count and overflow flag.
// Build option MATH_ACC_SAT_EN: saturate the accumulator instead of wrapping.
module math_acc_dump
  import math_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 dump,
  output logic [ACC_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0] dout_cnt,
  output logic                 dout_valid,
  output logic                 ovf,
  output logic                 busy
);

  acc_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic                 end_blk;

  logic [ACC_WIDTH-1:0] dout_q;
  logic [CNT_WIDTH-1:0] dout_cnt_q;
  logic                 dout_valid_q;
  logic                 dout_ovf_q;
  logic                 busy_q;

  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;

  assign din_ext = ACC_WIDTH'(sext(64'(din), WIDTH));

  math_sat_add #(
    .W(ACC_WIDTH)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (din_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  // Next-state: the first sample of a block is loaded (never added), later
  // samples accumulate; end of block is decided on post-update values.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    end_blk = 1'b0;
    if (ena) begin
      if (state_q == IDLE) begin
        if (din_valid) begin
          acc_d   = din_ext;
          cnt_d   = '0;
          len_d   = len;
          ovf_d   = 1'b0;
          end_blk = (len == '0) || dump;
          state_d = end_blk ? IDLE : RUN;
        end
      end else begin
        if (din_valid) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + 1'b1;
          ovf_d   = ovf_q | add_ovf;
          end_blk = (cnt_d == len_q) || dump;
        end else begin
          end_blk = dump;
        end
        if (end_blk) state_d = IDLE;
      end
    end
  end

  // State, accumulator and registered outputs; output fields hold between dumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      dout_q       <= '0;
      dout_cnt_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      busy_q       <= (state_d == RUN);
      dout_valid_q <= end_blk;
      if (end_blk) begin
        dout_q     <= acc_d;
        dout_cnt_q <= cnt_d;
        dout_ovf_q <= ovf_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_cnt   = dout_cnt_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = dout_ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_math_acc_dump.sv
// Scoreboard bench for math_acc_dump: the driver keeps a sample-list model of
// each block and queues the expected block result; a monitor pops and compares
// on every dout_valid and checks busy every cycle.
module tb_math_acc_dump;

  localparam int W    = 16;
  localparam int AW   = 16;
  localparam int CW   = 8;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          din_valid;
  logic [W-1:0]  din;
  logic [CW-1:0] len;
  logic          dump;
  logic [AW-1:0] dout;
  logic [CW-1:0] dout_cnt;
  logic          dout_valid;
  logic          ovf;
  logic          busy;

  math_acc_dump #(
    .WIDTH    (W),
    .ACC_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din_valid (din_valid),
    .din       (din),
    .len       (len),
    .dump      (dump),
    .dout      (dout),
    .dout_cnt  (dout_cnt),
    .dout_valid(dout_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cnt;
    int ov;
  } exp_t;

  exp_t exp_q[$];
  int   samples[$];
  int   blk_len;
  bit   in_blk;
  bit   exp_busy;
  bit   mon_en;
  int   checks;
  int   errors;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: sum the block's sample list in plain integer arithmetic.
  task automatic end_block();
    exp_t e;
    int   s;
    int   t;
    logic signed [AW-1:0] wrapped;
    s = samples[0];
    e.ov = 0;
    for (int i = 1; i < samples.size(); i++) begin
      t = s + samples[i];
      if (t > MAXV || t < MINV) begin
        e.ov = 1;
`ifdef MATH_ACC_SAT_EN
        t = (t > MAXV) ? MAXV : MINV;
`endif
      end
      wrapped = t[AW-1:0];
      s = int'(wrapped);
    end
    e.sum = s;
    e.cnt = samples.size() - 1;
    exp_q.push_back(e);
    in_blk = 0;
  endtask

  // One clock: drive at negedge, update the model, return at the next negedge.
  task automatic step(input bit v, input int d, input int l, input bit dmp, input bit e);
    ena       = e;
    din_valid = v;
    din       = d[W-1:0];
    len       = l[CW-1:0];
    dump      = dmp;
    if (e) begin
      if (v) begin
        if (!in_blk) begin
          samples.delete();
          blk_len = l;
          in_blk  = 1;
        end
        samples.push_back(d);
        if (samples.size() == blk_len + 1 || dmp) end_block();
      end else if (dmp && in_blk) begin
        end_block();
      end
    end
    exp_busy = in_blk;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    samples.delete();
    in_blk   = 0;
    exp_busy = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sampled 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        chk("busy", int'(busy), int'(exp_busy));
        if (dout_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_dout_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("dout", int'($signed(dout)), e.sum);
            chk("dout_cnt", int'(dout_cnt), e.cnt & 32'hFF);
            chk("ovf", int'(ovf), e.ov);
          end
        end else if (exp_q.size() != 0) begin
          chk("missing_dout_valid", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int d;
    checks = 0; errors = 0; mon_en = 0; in_blk = 0; exp_busy = 0; blk_len = 0;
    rst_n = 1'b0; ena = 0; din_valid = 0; din = '0; len = '0; dump = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_cnt", int'(dout_cnt), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    mon_en = 1;

    // len=3, samples 1..4
    step(1, 1, 3, 0, 1); step(1, 2, 3, 0, 1); step(1, 3, 3, 0, 1); step(1, 4, 3, 0, 1);
    idle(2);
    // single-sample blocks
    step(1, -5, 0, 0, 1); step(1, 7, 0, 0, 1);
    idle(2);
    // dump alongside a sample, then dump in IDLE
    step(1, 100, 9, 0, 1); step(1, 200, 9, 1, 1);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
    idle(1);
    // dump in RUN without a sample
    step(1, 11, 9, 0, 1); step(1, -3, 9, 0, 1); step(0, 0, 9, 1, 1);
    idle(1);
    // overflow
    step(1, 32767, 1, 0, 1); step(1, 1, 1, 0, 1);
    step(1, -32768, 1, 0, 1); step(1, -1, 1, 0, 1);
    idle(1);
    // ena gaps with din_valid asserted while disabled
    step(1, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 50, 2, 1, 0);
    step(1, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 50, 2, 1, 0);
    step(1, 1, 2, 0, 1);
    idle(2);
    // reset mid-block
    step(1, 9, 3, 0, 1); step(1, 9, 3, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2, 3, 0, 1);
    idle(2);
    // back-to-back: dump then immediate new block
    step(1, 5, 4, 0, 1); step(0, 0, 4, 1, 1); step(1, 6, 1, 0, 1); step(1, 7, 1, 0, 1);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom % 4)
        0:       d = MAXV - int'($urandom % 4);
        1:       d = MINV + int'($urandom % 4);
        default: d = int'($urandom_range(0, 400)) - 200;
      endcase
      step(($urandom % 4) != 0, d,
           (($urandom % 3) == 0) ? 0 : int'($urandom_range(1, 12)),
           ($urandom % 12) == 0, ($urandom % 8) != 0);
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
